// File: rtl/collision_avoid_ctrl_if.sv
`default_nettype none
// collision_avoid_ctrl_if: drive-request, crash-flag and motor-output bundle between controller and its surroundings.
interface collision_avoid_ctrl_if #(
  parameter int PWM_BITS = 8
);
  logic                crash_in;
  logic                drive_en;
  logic [PWM_BITS-1:0] speed;
  logic                pwm_left;
  logic                pwm_right;
  logic                dir_left;
  logic                dir_right;
  logic [2:0]          state;
  logic                avoid_busy;

  modport master (
    output crash_in, drive_en, speed,
    input  pwm_left, pwm_right, dir_left, dir_right, state, avoid_busy
  );

  modport slave (
    input  crash_in, drive_en, speed,
    output pwm_left, pwm_right, dir_left, dir_right, state, avoid_busy
  );
endinterface
`default_nettype wire

// File: rtl/collision_avoid_ctrl.sv
`default_nettype none
// collision_avoid_ctrl: crash-triggered brake/reverse/turn sequencer producing per-wheel PWM and direction.
// Define CRASH_FILTER_EN to build a FILTER_LEN-sample debounce on the synchronised crash flag.
module collision_avoid_ctrl #(
  parameter int PWM_BITS    = 8,
  parameter int TIMER_W     = 17,
  parameter int BRAKE_CYC   = 1000,
  parameter int REVERSE_CYC = 50000,
  parameter int TURN_CYC    = 30000,
  parameter int AVOID_DUTY  = 128
`ifdef CRASH_FILTER_EN
  , parameter int FILTER_LEN = 4
`endif
) (
  input wire                    clk,
  input wire                    rst_n,
  collision_avoid_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRIVE   = 3'd1,
    ST_BRAKE   = 3'd2,
    ST_REVERSE = 3'd3,
    ST_TURN    = 3'd4
  } state_t;

  localparam logic [TIMER_W-1:0]  BRAKE_LD   = TIMER_W'(BRAKE_CYC - 1);
  localparam logic [TIMER_W-1:0]  REVERSE_LD = TIMER_W'(REVERSE_CYC - 1);
  localparam logic [TIMER_W-1:0]  TURN_LD    = TIMER_W'(TURN_CYC - 1);
  localparam logic [PWM_BITS-1:0] AVOID_D    = PWM_BITS'(AVOID_DUTY);
  localparam logic [PWM_BITS-1:0] PWM_MAX    = '1;

  logic [2:0]          state_r;
  state_t              state_d;
  logic [TIMER_W-1:0]  timer_r;
  logic [TIMER_W-1:0]  timer_d;
  logic                sync1_r;
  logic                crash_s_r;
  logic                crash_f;
  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic [PWM_BITS-1:0] pwm_cnt_d;
  logic [PWM_BITS-1:0] duty_r;
  logic [PWM_BITS-1:0] duty_d;
  logic [PWM_BITS-1:0] src_duty;
  logic                pwm_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r   <= 1'b0;
      crash_s_r <= 1'b0;
    end else begin
      sync1_r   <= bus.crash_in;
      crash_s_r <= sync1_r;
    end
  end

`ifdef CRASH_FILTER_EN
  localparam int FCNT_W = $clog2(FILTER_LEN + 1);

  logic [FCNT_W-1:0] fcnt_r;
  logic              filt_r;

  // Counts consecutive samples that disagree with the filtered value; flips on the FILTER_LEN-th.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_r <= '0;
      filt_r <= 1'b0;
    end else if (crash_s_r == filt_r) begin
      fcnt_r <= '0;
    end else if (fcnt_r == FCNT_W'(FILTER_LEN - 1)) begin
      filt_r <= crash_s_r;
      fcnt_r <= '0;
    end else begin
      fcnt_r <= fcnt_r + FCNT_W'(1);
    end
  end

  assign crash_f = filt_r;
`else
  assign crash_f = crash_s_r;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      timer_r <= '0;
    end else begin
      state_r <= state_d;
      timer_r <= timer_d;
    end
  end

  always_comb begin
    state_d = state_t'(state_r);
    timer_d = timer_r;
    if (!bus.drive_en) begin
      state_d = ST_IDLE;
      timer_d = '0;
    end else begin
      case (state_r)
        ST_IDLE: state_d = ST_DRIVE;
        ST_DRIVE: begin
          if (crash_f) begin
            state_d = ST_BRAKE;
            timer_d = BRAKE_LD;
          end
        end
        ST_BRAKE: begin
          if (timer_r == '0) begin
            state_d = ST_REVERSE;
            timer_d = REVERSE_LD;
          end else begin
            timer_d = timer_r - 1'b1;
          end
        end
        ST_REVERSE: begin
          if (timer_r == '0) begin
            state_d = ST_TURN;
            timer_d = TURN_LD;
          end else begin
            timer_d = timer_r - 1'b1;
          end
        end
        ST_TURN: begin
          if (timer_r == '0) begin
            state_d = ST_DRIVE;
          end else begin
            timer_d = timer_r - 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Duty follows the state being entered; IDLE/BRAKE clear it at once instead of waiting for a wrap.
  always_comb begin
    src_duty  = '0;
    pwm_cnt_d = pwm_cnt_r + 1'b1;
    case (state_d)
      ST_DRIVE:            src_duty = bus.speed;
      ST_REVERSE, ST_TURN: src_duty = AVOID_D;
      default:             src_duty = '0;
    endcase
    duty_d = duty_r;
    if (state_d == ST_IDLE || state_d == ST_BRAKE) begin
      duty_d = '0;
    end else if (pwm_cnt_r == PWM_MAX) begin
      duty_d = src_duty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_r <= '0;
      duty_r    <= '0;
      pwm_r     <= 1'b0;
    end else begin
      pwm_cnt_r <= pwm_cnt_d;
      duty_r    <= duty_d;
      pwm_r     <= (pwm_cnt_d < duty_d);
    end
  end

  assign bus.pwm_left   = pwm_r;
  assign bus.pwm_right  = pwm_r;
  assign bus.dir_left   = !(state_r == ST_REVERSE || state_r == ST_TURN);
  assign bus.dir_right  = (state_r != ST_REVERSE);
  assign bus.state      = state_r;
  assign bus.avoid_busy = (state_r == ST_BRAKE) || (state_r == ST_REVERSE) || (state_r == ST_TURN);

endmodule
`default_nettype wire
